// File: rtl/divx.sv
// divx - iterative fixed-point divider with signed/unsigned and rounding modes.
//
// Computes a / b in a WIDTH-bit format with FBITS fractional bits. It uses
// restoring division on the operand magnitudes and produces one quotient bit
// per clock over WIDTH+FBITS+1 iterations. The last iteration is a guard bit
// used for rounding. A final cycle then applies rounding, sign and the
// overflow check.
//
// Ports:
//   clk   - clock
//   rst   - synchronous, active-high reset
//   start - begin a calculation (ignored while busy)
//   sgn   - 1: a, b, val are two's complement; 0: unsigned
//   rnd   - 1: round half away from zero; 0: truncate toward zero
//   a, b  - dividend, divisor
//   busy  - calculation in progress
//   done  - one-cycle pulse when a request finishes (any outcome)
//   valid - val holds a valid result
//   dbz   - last request was a divide by zero
//   ovf   - last result did not fit the output format
//   val   - quotient
module divx #(
    parameter int WIDTH = 16,
    parameter int FBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic             rnd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             dbz,
    output logic             ovf,
    output logic [WIDTH-1:0] val
);

    localparam int ITER = WIDTH + FBITS + 1;
    localparam int QW   = WIDTH + FBITS + 1;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;      // partial remainder, always < divisor
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [QW-1:0]    qr;       // dividend bits shift out, quotient bits shift in
    logic             sgn_r;
    logic             rnd_r;
    logic             neg;

    // Operand magnitudes; -2^(WIDTH-1) negates to itself, which reads
    // correctly as the unsigned magnitude 2^(WIDTH-1).
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        mag_a = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b = (sgn && b[WIDTH-1]) ? -b : b;
    end

    // One restoring step. The WIDTH+1 bit trial value is the accumulator.
    // When the divisor fits, the true difference is below 2^WIDTH. The
    // subtraction can therefore be done at WIDTH bits.
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        trial = {rem, qr[QW-1]};
        fits  = (trial >= {1'b0, dvs});
        diff  = trial[WIDTH-1:0] - dvs;
    end

    // Finalise: drop the guard bit, optionally round on it, then range-check
    // the magnitude against the limit for the selected signedness.
    logic [QW-1:0]    m;
    logic [QW-1:0]    half;
    logic             over;
    logic [WIDTH-1:0] res;

    always_comb begin
        half          = '0;
        half[WIDTH-1] = 1'b1;
        m = {1'b0, qr[QW-1:1]} + {{(QW-1){1'b0}}, rnd_r & qr[0]};
        if (!sgn_r) begin
            over = |m[QW-1:WIDTH];
        end else if (neg) begin
            over = (m > half);
        end else begin
            over = (m >= half);
        end
        res = neg ? -m[WIDTH-1:0] : m[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            dvs   <= '0;
            qr    <= '0;
            sgn_r <= 1'b0;
            rnd_r <= 1'b0;
            neg   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
            val   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        valid <= 1'b0;
                        ovf   <= 1'b0;
                        if (b == '0) begin
                            done <= 1'b1;
                            dbz  <= 1'b1;
                            val  <= '0;
                        end else begin
                            dbz   <= 1'b0;
                            sgn_r <= sgn;
                            rnd_r <= rnd;
                            neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rem   <= '0;
                            dvs   <= mag_b;
                            qr    <= {mag_a, {(FBITS + 1){1'b0}}};
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= fits ? diff : trial[WIDTH-1:0];
                    qr  <= {qr[QW-2:0], fits};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (over) begin
                        ovf   <= 1'b1;
                        valid <= 1'b0;
                        val   <= '0;
                    end else begin
                        ovf   <= 1'b0;
                        valid <= 1'b1;
                        val   <= res;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divx.sv
// tb_divx - directed and random checks of divx at WIDTH=8, FBITS=4.
module tb_divx;

    localparam int W    = 8;
    localparam int F    = 4;
    localparam int ITER = W + F + 1;
    localparam int LAT  = ITER + 2;   // negedges from start until done is seen

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sgn;
    logic         rnd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         valid;
    logic         dbz;
    logic         ovf;
    logic [W-1:0] val;

    divx #(.WIDTH(W), .FBITS(F)) dut (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn), .rnd(rnd),
        .a(a), .b(b), .busy(busy), .done(done), .valid(valid),
        .dbz(dbz), .ovf(ovf), .val(val)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] v;
        logic         vld;
        logic         dz;
        logic         of;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [W-1:0] v, input logic vld,
                                input logic dz, input logic of);
        exp_t e;
        e.v = v; e.vld = vld; e.dz = dz; e.of = of;
        return e;
    endfunction

    // Integer reference: scaled quotient with one extra bit, then round/truncate.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic r);
        longint xv, yv, mx, my, q, m, v;
        logic   ng, of;
        logic [W-1:0] lo;
        xv = s ? longint'($signed(x)) : longint'(x);
        yv = s ? longint'($signed(y)) : longint'(y);
        if (yv == 0) return mk('0, 1'b0, 1'b1, 1'b0);
        mx = (xv < 0) ? -xv : xv;
        my = (yv < 0) ? -yv : yv;
        ng = (xv < 0) != (yv < 0);
        q  = (mx * (64'sd1 <<< (F + 1))) / my;
        m  = r ? (q + 1) / 2 : q / 2;
        v  = ng ? -m : m;
        of = s ? (v < -(64'sd1 <<< (W - 1)) || v > (64'sd1 <<< (W - 1)) - 1)
               : (v > (64'sd1 <<< W) - 1);
        lo = W'(v);
        return of ? mk('0, 1'b0, 1'b0, 1'b1) : mk(lo, 1'b1, 1'b0, 1'b0);
    endfunction

    // Called at a negedge; the request is taken on the following posedge.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic s, input logic r, input exp_t e);
        a = x; b = y; sgn = s; rnd = r; start = 1'b1;
        sb.push_back(e);
    endtask

    // Waits for done with a bound. Optionally pulses start with new operands
    // mid-calculation; that second request must have no effect.
    task automatic wait_result(input string tag, input int exp_lat, input bit inject);
        int   cyc;
        exp_t e;
        @(negedge clk);
        cyc   = 1;
        start = 1'b0;
        chk({tag, "_busy_first"}, busy, exp_lat > 1);
        chk({tag, "_valid_cleared"}, valid, (exp_lat == 1) ? 1'b0 : 1'b0);
        chk({tag, "_ovf_cleared"}, ovf, 0);
        while (!done && cyc < 200) begin
            if (inject && cyc == 4) begin
                a = 8'h11; b = 8'h01; sgn = 1'b0; rnd = 1'b1; start = 1'b1;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_sb_size"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_val"}, val, e.v);
            chk({tag, "_valid"}, valid, e.vld);
            chk({tag, "_dbz"}, dbz, e.dz);
            chk({tag, "_ovf"}, ovf, e.of);
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int dcount;
        logic [W-1:0] ra, rb;
        logic rs, rr;

        rst = 1'b1; start = 1'b0; sgn = 1'b0; rnd = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", valid, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_val", val, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic unsigned 3.0 / 2.0
        start_op(8'h30, 8'h20, 1'b0, 1'b0, mk(8'h18, 1'b1, 1'b0, 1'b0));
        wait_result("u_3div2", LAT, 1'b0);
        idle_check("u_3div2");

        // Rounding, unsigned
        start_op(8'h20, 8'h30, 1'b0, 1'b0, mk(8'h0A, 1'b1, 1'b0, 1'b0));
        wait_result("u_trunc", LAT, 1'b0);
        idle_check("u_trunc");
        start_op(8'h20, 8'h30, 1'b0, 1'b1, mk(8'h0B, 1'b1, 1'b0, 1'b0));
        wait_result("u_round_up", LAT, 1'b0);
        idle_check("u_round_up");
        start_op(8'h10, 8'h30, 1'b0, 1'b1, mk(8'h05, 1'b1, 1'b0, 1'b0));
        wait_result("u_round_dn", LAT, 1'b0);
        idle_check("u_round_dn");

        // Signed
        start_op(8'hE0, 8'h30, 1'b1, 1'b0, mk(8'hF6, 1'b1, 1'b0, 1'b0));
        wait_result("s_trunc", LAT, 1'b0);
        idle_check("s_trunc");
        start_op(8'hE0, 8'h30, 1'b1, 1'b1, mk(8'hF5, 1'b1, 1'b0, 1'b0));
        wait_result("s_round", LAT, 1'b0);
        idle_check("s_round");
        start_op(8'h80, 8'h10, 1'b1, 1'b0, mk(8'h80, 1'b1, 1'b0, 1'b0));
        wait_result("s_most_neg", LAT, 1'b0);
        idle_check("s_most_neg");

        // Overflow boundaries
        start_op(8'h40, 8'h08, 1'b1, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b1));
        wait_result("s_ovf_pos", LAT, 1'b0);
        idle_check("s_ovf_pos");
        start_op(8'h40, 8'h08, 1'b0, 1'b0, mk(8'h80, 1'b1, 1'b0, 1'b0));
        wait_result("u_no_ovf", LAT, 1'b0);
        idle_check("u_no_ovf");
        start_op(8'h80, 8'hF0, 1'b1, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b1));
        wait_result("s_ovf_negneg", LAT, 1'b0);
        idle_check("s_ovf_negneg");

        // Divide by zero after a nonzero result: val must clear
        start_op(8'h30, 8'h20, 1'b0, 1'b0, mk(8'h18, 1'b1, 1'b0, 1'b0));
        wait_result("pre_dbz", LAT, 1'b0);
        idle_check("pre_dbz");
        start_op(8'h55, 8'h00, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b1, 1'b0));
        wait_result("dbz", 1, 1'b0);
        idle_check("dbz");
        chk("dbz_busy_after", busy, 0);

        // Start while busy is ignored
        start_op(8'h30, 8'h20, 1'b0, 1'b0, mk(8'h18, 1'b1, 1'b0, 1'b0));
        wait_result("ignore_start", LAT, 1'b1);
        idle_check("ignore_start");

        // Back-to-back: second start issued in the done cycle
        start_op(8'h20, 8'h30, 1'b0, 1'b1, mk(8'h0B, 1'b1, 1'b0, 1'b0));
        wait_result("b2b_first", LAT, 1'b0);
        start_op(8'hE0, 8'h30, 1'b1, 1'b0, mk(8'hF6, 1'b1, 1'b0, 1'b0));
        wait_result("b2b_second", LAT, 1'b0);
        idle_check("b2b_second");

        // Reset mid-calculation
        start = 1'b1; a = 8'h30; b = 8'h20; sgn = 1'b0; rnd = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_dbz", dbz, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_val", val, 0);
        dcount = 0;
        repeat (ITER + 4) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("midrst_no_done", dcount, 0);

        // Random operands against the integer model
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(1, 255));
            rs = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            start_op(ra, rb, rs, rr, model(ra, rb, rs, rr));
            wait_result($sformatf("rand%0d", i), LAT, 1'b0);
            idle_check($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
